// File: rtl/uart_wb_if.sv
// Wishbone bus bundle for the UART register bank.
// The master modport drives the request side and the slave modport answers it.
interface uart_wb_if;
  logic       wb_cyc;
  logic       wb_stb;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_i,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_i,
    output wb_dat_o, wb_ack
  );
endinterface

// File: rtl/uart_wb_regs.sv
// 16550-style UART register bank behind a Wishbone slave port.
// Holds RBR/THR, IER, IIR/FCR, LCR, LSR and the DLAB-banked divisor latches,
// generates the baud tick and hands bytes to/from the serializer.
// Optional build macro UART_WB_IRQ_EN enables the registered interrupt output;
// without it irq is tied low.
module uart_wb_regs #(
  parameter logic [15:0] DEFAULT_DIV = 16'h0082,
  parameter logic [7:0]  DEFAULT_LCR = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  uart_wb_if.slave   wb,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_avail,
  output logic       rx_pop,
  output logic [7:0] lcr,
  output logic [7:0] fcr,
  output logic       baud_tick,
  output logic       irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_IIR  = 3'd2;
  localparam logic [2:0] ADDR_LCR  = 3'd3;
  localparam logic [2:0] ADDR_LSR  = 3'd5;

  logic [1:0]  ier;
  logic [15:0] divisor;
  logic [15:0] baud_cnt;
  logic        reload_pending;
  logic [1:0]  iir_id;
  logic [7:0]  rdata;
  logic        access;
  logic        wr;
  logic        rd;
  logic        dlab;

  // A new access is only sampled while no ack is outstanding, so a held
  // strobe is answered every second cycle.
  assign access = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;
  assign wr     = access & wb.wb_we;
  assign rd     = access & ~wb.wb_we;
  assign dlab   = lcr[7];

  // Interrupt identification: receive data outranks transmitter ready.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    iir_id = 2'b01;
    if (rx_avail)      iir_id = 2'b10;
    else if (tx_ready) iir_id = 2'b11;
  end

  // Read-data mux, selected by address and the DLAB bank bit.
  always_comb begin
    rdata = 8'h00;
    case (wb.wb_addr)
      ADDR_DATA: rdata = dlab ? divisor[7:0] : (rx_avail ? rx_data : 8'h00);
      ADDR_IER:  rdata = dlab ? divisor[15:8] : {6'b0, ier};
      ADDR_IIR:  rdata = {6'b0, iir_id};
      ADDR_LCR:  rdata = lcr;
      ADDR_LSR:  rdata = {2'b0, tx_ready, 4'b0, rx_avail};
      default:   rdata = 8'h00;
    endcase
  end

  // Bus response: ack and read data live for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wb.wb_ack   <= 1'b0;
      wb.wb_dat_o <= 8'h00;
    end else begin
      wb.wb_ack   <= access;
      wb.wb_dat_o <= rd ? rdata : 8'h00;
    end
  end

  // Register writes and the TX push / RX pop pulses, on the ack-raising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcr            <= DEFAULT_LCR;
      fcr            <= 8'h00;
      ier            <= 2'b00;
      divisor        <= DEFAULT_DIV;
      reload_pending <= 1'b0;
      tx_valid       <= 1'b0;
      tx_data        <= 8'h00;
      rx_pop         <= 1'b0;
    end else begin
      tx_valid       <= 1'b0;
      rx_pop         <= 1'b0;
      reload_pending <= 1'b0;
      if (wr) begin
        case (wb.wb_addr)
          ADDR_DATA: begin
            if (dlab) begin
              divisor[7:0]   <= wb.wb_dat_i;
              reload_pending <= 1'b1;
            end else if (tx_ready) begin
              tx_data  <= wb.wb_dat_i;
              tx_valid <= 1'b1;
            end
          end
          ADDR_IER: begin
            if (dlab) begin
              divisor[15:8]  <= wb.wb_dat_i;
              reload_pending <= 1'b1;
            end else begin
              ier <= wb.wb_dat_i[1:0];
            end
          end
          ADDR_IIR: fcr <= wb.wb_dat_i;
          ADDR_LCR: lcr <= wb.wb_dat_i;
          default:  ;
        endcase
      end
      if (rd && wb.wb_addr == ADDR_DATA && !dlab && rx_avail)
        rx_pop <= 1'b1;
    end
  end

  // Baud generator: count down from the divisor, tick and reload at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= 16'h0000;
      baud_tick <= 1'b0;
    end else if (divisor == 16'h0000) begin
      baud_cnt  <= 16'h0000;
      baud_tick <= 1'b0;
    end else if (reload_pending || baud_cnt == 16'h0000) begin
      baud_cnt  <= divisor;
      baud_tick <= 1'b0;
    end else if (baud_cnt == 16'h0001) begin
      baud_cnt  <= divisor;
      baud_tick <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt - 16'h0001;
      baud_tick <= 1'b0;
    end
  end

`ifdef UART_WB_IRQ_EN
  // Interrupt follows the enabled sources one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (ier[0] & rx_avail) | (ier[1] & tx_ready);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wb_regs.sv
// Directed bench for uart_wb_regs: a vector table of single bus transfers
// plus hand-written sequences for reset, baud timing, held strobe and irq.
module tb_uart_wb_regs;

`ifdef UART_WB_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_pop;
  logic [7:0] lcr;
  logic [7:0] fcr;
  logic       baud_tick;
  logic       irq;

  uart_wb_if bus ();

  uart_wb_regs dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (bus.slave),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_pop    (rx_pop),
    .lcr       (lcr),
    .fcr       (fcr),
    .baud_tick (baud_tick),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic       txr;
    logic       rxa;
    logic [7:0] rxd;
    logic [7:0] exp_dout;
    logic       exp_txv;
    logic       exp_pop;
  } vec_t;

  vec_t vecs[$];

  // One single-beat transfer; called and returns at posedge+1.
  task automatic xfer(input logic we, input logic [2:0] addr, input logic [7:0] din,
                      output logic [7:0] dout, output int lat,
                      output logic txv, output logic pop);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_addr  = addr;
    bus.wb_dat_i = din;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.wb_ack && lat < 8);
    dout = bus.wb_dat_o;
    txv  = tx_valid;
    pop  = rx_pop;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] din);
    logic [7:0] d;
    int l;
    logic t, p;
    xfer(1'b1, addr, din, d, l, t, p);
    check("write_latency", l, 1);
  endtask

  logic [7:0] dout;
  int         lat;
  logic       txv, pop;
  int         ticks, last_tick, acks;

  initial begin
    rst = 1'b1;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_addr = 3'd0; bus.wb_dat_i = 8'h00;
    tx_ready = 1'b0; rx_avail = 1'b0; rx_data = 8'h00;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.wb_ack, 0);
    check("rst_dat_o", bus.wb_dat_o, 0);
    check("rst_lcr", lcr, 8'h03);
    check("rst_fcr", fcr, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_pop", rx_pop, 0);
    check("rst_baud_tick", baud_tick, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- reset asserted mid-read ----
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_addr = 3'd3;
    @(posedge clk); #1;
    check("midrd_ack_before_rst", bus.wb_ack, 1);
    #2 rst = 1'b1;
    #1;
    check("midrd_ack_drops", bus.wb_ack, 0);
    check("midrd_dat_o_drops", bus.wb_dat_o, 0);
    @(posedge clk); #1;
    check("pending_under_rst", bus.wb_ack, 0);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("pending_discarded", bus.wb_ack, 0);

    // ---- vector table ----
    //               we    addr  din    txr   rxa   rxd    dout   txv   pop
    vecs.push_back('{1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0}); // LCR default
    vecs.push_back('{1'b1, 3'd3, 8'h83, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // DLAB on
    vecs.push_back('{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h82, 1'b0, 1'b0}); // DL1, no pop
    vecs.push_back('{1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // DL2
    vecs.push_back('{1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // DL2=00
    vecs.push_back('{1'b1, 3'd0, 8'h04, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // DL1=04, no push
    vecs.push_back('{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0}); // DL1 readback
    vecs.push_back('{1'b1, 3'd3, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // DLAB off
    vecs.push_back('{1'b1, 3'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0}); // THR push
    vecs.push_back('{1'b1, 3'd0, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // THR dropped
    vecs.push_back('{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1}); // RBR pop
    vecs.push_back('{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0}); // RBR empty
    vecs.push_back('{1'b0, 3'd5, 8'h00, 1'b1, 1'b1, 8'h11, 8'h21, 1'b0, 1'b0}); // LSR both
    vecs.push_back('{1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // LSR none
    vecs.push_back('{1'b0, 3'd4, 8'h00, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0}); // hole read
    vecs.push_back('{1'b1, 3'd6, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // hole write
    vecs.push_back('{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // hole read
    vecs.push_back('{1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // IER=FF
    vecs.push_back('{1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0}); // IER readback
    vecs.push_back('{1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0}); // IIR rx prio
    vecs.push_back('{1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0}); // IIR tx
    vecs.push_back('{1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0}); // IIR none
    vecs.push_back('{1'b1, 3'd2, 8'hC7, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}); // FCR write
    vecs.push_back('{1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0}); // LCR intact

    foreach (vecs[i]) begin
      tx_ready = vecs[i].txr;
      rx_avail = vecs[i].rxa;
      rx_data  = vecs[i].rxd;
      xfer(vecs[i].we, vecs[i].addr, vecs[i].din, dout, lat, txv, pop);
      check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_dat_o", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_tx_valid", i), txv, vecs[i].exp_txv);
      check($sformatf("vec%0d_rx_pop", i), pop, vecs[i].exp_pop);
      if (vecs[i].exp_txv)
        check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].din);
      check($sformatf("vec%0d_ack_one_cycle", i), bus.wb_ack, 0);
      check($sformatf("vec%0d_pulses_end", i), {tx_valid, rx_pop}, 0);
    end
    check("fcr_out", fcr, 8'hC7);
    check("lcr_out", lcr, 8'h03);

    // ---- baud tick with divisor 4 ----
    tx_ready = 1'b0; rx_avail = 1'b0;
    ticks = 0; last_tick = -1;
    for (int c = 0; c < 40; c++) begin
      if (baud_tick) begin
        if (last_tick >= 0) check("baud_div4_gap", c - last_tick, 4);
        last_tick = c;
        ticks++;
      end
      @(posedge clk); #1;
    end
    check("baud_div4_count", ticks, 10);

    // ---- divisor 1: tick every cycle ----
    wr(3'd3, 8'h83);
    wr(3'd0, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    ticks = 0;
    for (int c = 0; c < 10; c++) begin
      ticks += int'(baud_tick);
      @(posedge clk); #1;
    end
    check("baud_div1_count", ticks, 10);

    // ---- divisor 0: tick held low ----
    wr(3'd0, 8'h00);
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      ticks += int'(baud_tick);
      @(posedge clk); #1;
    end
    check("baud_div0_count", ticks, 0);
    wr(3'd0, 8'h04);
    wr(3'd3, 8'h03);

    // ---- held strobe: LSR read acked every second cycle ----
    tx_ready = 1'b1; rx_avail = 1'b1;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = 3'd5;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack_c%0d", c), bus.wb_ack, (c % 2 == 0) ? 1 : 0);
      if (bus.wb_ack) begin
        acks++;
        check($sformatf("held_lsr_c%0d", c), bus.wb_dat_o, 8'h21);
      end
    end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    check("held_ack_count", acks, 3);
    @(posedge clk); #1;

    // ---- interrupt ----
    rx_avail = 1'b0;
    wr(3'd1, 8'h01);
    check("irq_idle", irq, 0);
    rx_avail = 1'b1;
    #1;
    check("irq_not_yet", irq, 0);
    @(posedge clk); #1;
    check("irq_rx", irq, EXP_IRQ);
    xfer(1'b0, 3'd2, 8'h00, dout, lat, txv, pop);
    check("irq_iir", dout, 8'h02);
    check("irq_iir_no_pop", pop, 0);
    rx_avail = 1'b0;
    @(posedge clk); #1;
    check("irq_clear", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
